// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one AXI4-Stream UART transmitter among N_PORTS packet
// sources. Round-robin arbitration with the grant locked from first beat to tlast,
// and an optional one-byte source-ID header ahead of each packet.

module uart_tx_arbiter #(
    parameter int unsigned          N_PORTS    = 4,
    parameter int unsigned          DATA_WIDTH = 8,
    parameter bit                   HEADER_EN  = 1'b1,
    parameter logic [DATA_WIDTH-1:0] HDR_BASE  = DATA_WIDTH'(8'hF0),
    localparam int unsigned         IDX_W      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic [N_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [N_PORTS-1:0]            s_axis_tvalid,
    input  logic [N_PORTS-1:0]            s_axis_tlast,
    output logic [N_PORTS-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          grant_valid,
    output logic [IDX_W-1:0]              grant_idx
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HEADER  = 2'd1,
        S_PAYLOAD = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        last_grant_q, last_grant_d;
    logic [IDX_W-1:0]        grant_idx_q, grant_idx_d;
    logic [DATA_WIDTH-1:0]   hdr_q, hdr_d;

    logic [DATA_WIDTH-1:0]   src_data [N_PORTS];
    logic [IDX_W-1:0]        arb_idx;
    logic [DATA_WIDTH-1:0]   g_data;
    logic                    g_valid;
    logic                    g_last;

    // Round-robin pick: first requester after 'last', wrapping around.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_PORTS-1:0] req,
                                                 input logic [IDX_W-1:0]   last);
        logic [IDX_W-1:0] pick;
        logic             found;
        int unsigned      cand;
        pick  = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned i = 1; i <= N_PORTS; i++) begin
            cand = (32'(last) + i) % N_PORTS;
            if (!found && req[IDX_W'(cand)]) begin
                found = 1'b1;
                pick  = IDX_W'(cand);
            end
        end
        return pick;
    endfunction

    // Unpack the flat source data bus into one word per port.
    for (genvar p = 0; p < N_PORTS; p++) begin : g_unpack
        assign src_data[p] = s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
    end

    // Arbitration winner among the current requesters.
    assign arb_idx = rr_pick(s_axis_tvalid, last_grant_q);

    // Signals of the currently locked source.
    assign g_data  = src_data[grant_idx_q];
    assign g_valid = s_axis_tvalid[grant_idx_q];
    assign g_last  = s_axis_tlast[grant_idx_q];

    // State and grant registers; reset aborts any packet in flight.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= S_IDLE;
            last_grant_q <= IDX_W'(N_PORTS - 1);
            grant_idx_q  <= '0;
            hdr_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_idx_q  <= grant_idx_d;
            hdr_q        <= hdr_d;
        end
    end

    // Next-state logic: grant in IDLE, header handshake, release on tlast.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_idx_d  = grant_idx_q;
        hdr_d        = hdr_q;
        unique case (state_q)
            S_IDLE: begin
                if (|s_axis_tvalid) begin
                    grant_idx_d = arb_idx;
                    hdr_d       = HDR_BASE | DATA_WIDTH'(arb_idx);
                    state_d     = HEADER_EN ? S_HEADER : S_PAYLOAD;
                end
            end
            S_HEADER: begin
                if (m_axis_tready) begin
                    state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (g_valid && m_axis_tready && g_last) begin
                    last_grant_d = grant_idx_q;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode: header from register, payload passed straight through.
    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        s_axis_tready = '0;
        grant_valid   = 1'b0;
        unique case (state_q)
            S_HEADER: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = hdr_q;
                grant_valid   = 1'b1;
            end
            S_PAYLOAD: begin
                m_axis_tvalid              = g_valid;
                m_axis_tdata               = g_data;
                s_axis_tready[grant_idx_q] = m_axis_tready;
                grant_valid                = 1'b1;
            end
            default: begin
                m_axis_tvalid = 1'b0;
            end
        endcase
    end

    assign grant_idx = grant_idx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle table for directed sequences, randomized
// packet traffic against a stream-level model, header-less and reset corners.

module tb_uart_tx_arbiter;

    logic        clk;
    logic        arst;
    logic [31:0] s_tdata;
    logic [3:0]  s_tvalid;
    logic [3:0]  s_tlast;
    logic [3:0]  s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        gv;
    logic [1:0]  gidx;

    logic [31:0] n_tdata;
    logic [3:0]  n_tvalid;
    logic [3:0]  n_tlast;
    logic [3:0]  n_tready_s;
    logic [7:0]  n_mdata;
    logic        n_mvalid;
    logic        n_mready;
    logic        n_gv;
    logic [1:0]  n_gidx;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(
        .N_PORTS(4), .DATA_WIDTH(8), .HEADER_EN(1'b1), .HDR_BASE(8'hF0)
    ) dut (
        .clk(clk), .arst(arst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .grant_valid(gv), .grant_idx(gidx)
    );

    uart_tx_arbiter #(
        .N_PORTS(4), .DATA_WIDTH(8), .HEADER_EN(1'b0), .HDR_BASE(8'hF0)
    ) dut_nh (
        .clk(clk), .arst(arst),
        .s_axis_tdata(n_tdata), .s_axis_tvalid(n_tvalid), .s_axis_tlast(n_tlast),
        .s_axis_tready(n_tready_s),
        .m_axis_tdata(n_mdata), .m_axis_tvalid(n_mvalid), .m_axis_tready(n_mready),
        .grant_valid(n_gv), .grant_idx(n_gidx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  tv;
        logic [3:0]  tl;
        logic [31:0] td;
        logic        rdy;
        logic        ev;
        logic [7:0]  ed;
        logic        eg;
        logic [1:0]  ei;
        logic [3:0]  es;
    } vec_t;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } beat_t;

    vec_t       vecs[$];
    beat_t      src_q [4][$];
    beat_t      mdl_q [4][$];
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         bub [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [3:0] tv, input logic [3:0] tl, input logic [31:0] td,
                           input logic rdy, input logic ev, input logic [7:0] ed,
                           input logic eg, input logic [1:0] ei, input logic [3:0] es);
        vec_t v;
        v.tv = tv; v.tl = tl; v.td = td; v.rdy = rdy;
        v.ev = ev; v.ed = ed; v.eg = eg; v.ei = ei; v.es = es;
        vecs.push_back(v);
    endtask

    task automatic zero_inputs();
        s_tdata = '0; s_tvalid = '0; s_tlast = '0; m_tready = 1'b0;
        n_tdata = '0; n_tvalid = '0; n_tlast = '0; n_mready = 1'b0;
    endtask

    // Reset both instances and check the reset state of the main one.
    task automatic do_reset();
        arst = 1'b1;
        zero_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mvalid", 32'(m_tvalid), 32'd0);
        chk("rst_mdata", 32'(m_tdata), 32'd0);
        chk("rst_gv", 32'(gv), 32'd0);
        chk("rst_gidx", 32'(gidx), 32'd0);
        chk("rst_sready", 32'(s_tready), 32'd0);
        @(posedge clk);
        #1;
        arst = 1'b0;
    endtask

    task automatic gen_packets(input int p, input int npk, input int minlen, input int maxlen);
        beat_t b;
        for (int k = 0; k < npk; k++) begin
            int len;
            len = $urandom_range(maxlen, minlen);
            for (int j = 0; j < len; j++) begin
                b.data = 8'($urandom);
                b.last = (j == len - 1);
                src_q[p].push_back(b);
            end
        end
    endtask

    // Stream-level model: round-robin over ports that still have packets,
    // each packet emitted whole, preceded by its header byte.
    task automatic build_expected();
        int    last;
        int    pick;
        beat_t b;
        exp_q.delete();
        for (int p = 0; p < 4; p++) mdl_q[p] = src_q[p];
        last = 3;
        forever begin
            pick = -1;
            for (int i = 1; i <= 4; i++) begin
                int c;
                c = (last + i) % 4;
                if (pick < 0 && mdl_q[c].size() > 0) pick = c;
            end
            if (pick < 0) break;
            exp_q.push_back(8'hF0 | 8'(pick));
            do begin
                b = mdl_q[pick].pop_front();
                exp_q.push_back(b.data);
            end while (!b.last);
            last = pick;
        end
    endtask

    task automatic drive_sources();
        for (int p = 0; p < 4; p++) begin
            if (bub[p] > 0) begin
                s_tvalid[p]       = 1'b0;
                s_tlast[p]        = 1'b0;
                s_tdata[p*8 +: 8] = 8'($urandom);
                bub[p]--;
            end else if (src_q[p].size() > 0) begin
                s_tvalid[p]       = 1'b1;
                s_tlast[p]        = src_q[p][0].last;
                s_tdata[p*8 +: 8] = src_q[p][0].data;
            end else begin
                s_tvalid[p]       = 1'b0;
                s_tlast[p]        = 1'b0;
                s_tdata[p*8 +: 8] = 8'h00;
            end
        end
    endtask

    function automatic logic ready_for(input int rmode, input int cyc);
        if (rmode == 0) return 1'b1;
        if (rmode == 1) return 1'($urandom_range(1, 0));
        return (cyc % 10 == 9);
    endfunction

    // Play the queued packets through the DUT and compare the output stream.
    task automatic run_traffic(input int rmode, input bit bub_en, input int budget, input string tag);
        int         cyc;
        bit         done;
        bit         hs [4];
        logic       prev_v, prev_r;
        logic [7:0] prev_d;
        logic [3:0] allowed;
        int         n;
        build_expected();
        obs_q.delete();
        prev_v = 1'b0; prev_r = 1'b1; prev_d = '0;
        cyc = 0;
        for (int p = 0; p < 4; p++) bub[p] = 0;
        drive_sources();
        m_tready = ready_for(rmode, cyc);
        done = (exp_q.size() == 0);
        while (!done && cyc < budget) begin
            @(negedge clk);
            if (prev_v && !prev_r) begin
                chk($sformatf("%s_hold_valid", tag), 32'(m_tvalid), 32'd1);
                chk($sformatf("%s_hold_data", tag), 32'(m_tdata), 32'(prev_d));
            end
            allowed = gv ? (4'b0001 << gidx) : 4'b0000;
            chk($sformatf("%s_sready_grant", tag), 32'(s_tready & ~allowed), 32'd0);
            for (int p = 0; p < 4; p++) hs[p] = s_tvalid[p] && s_tready[p];
            if (m_tvalid && m_tready) obs_q.push_back(m_tdata);
            prev_v = m_tvalid; prev_r = m_tready; prev_d = m_tdata;
            @(posedge clk);
            #1;
            for (int p = 0; p < 4; p++) begin
                if (hs[p]) begin
                    beat_t b;
                    b = src_q[p].pop_front();
                    if (!b.last && bub_en && $urandom_range(2, 0) == 0)
                        bub[p] = $urandom_range(3, 1);
                end
            end
            cyc++;
            drive_sources();
            m_tready = ready_for(rmode, cyc);
            done = (obs_q.size() >= exp_q.size()) && (src_q[0].size() == 0) &&
                   (src_q[1].size() == 0) && (src_q[2].size() == 0) && (src_q[3].size() == 0);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d beats expected %0d", tag, obs_q.size(), exp_q.size());
        end
        chk($sformatf("%s_len", tag), 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_beat%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
        for (int p = 0; p < 4; p++) src_q[p].delete();
        zero_inputs();
        @(negedge clk);
        chk($sformatf("%s_end_idle", tag), 32'(gv), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] nobs[$];
        logic [3:0] hsn;
        beat_t      b;

        arst = 1'b1;
        zero_inputs();

        // tv, tl, td, rdy | mvalid, mdata, gv, gidx, sready
        add_vec(4'b0100, 4'b0000, 32'h0011_0000, 1, 0, 8'h00, 0, 2'd0, 4'b0000);
        add_vec(4'b0100, 4'b0000, 32'h0011_0000, 1, 1, 8'hF2, 1, 2'd2, 4'b0000);
        add_vec(4'b0100, 4'b0000, 32'h0011_0000, 1, 1, 8'h11, 1, 2'd2, 4'b0100);
        add_vec(4'b0100, 4'b0000, 32'h0022_0000, 0, 1, 8'h22, 1, 2'd2, 4'b0000);
        add_vec(4'b0100, 4'b0000, 32'h0022_0000, 1, 1, 8'h22, 1, 2'd2, 4'b0100);
        add_vec(4'b0100, 4'b0100, 32'h0033_0000, 1, 1, 8'h33, 1, 2'd2, 4'b0100);
        add_vec(4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 8'h00, 0, 2'd2, 4'b0000);
        add_vec(4'b0010, 4'b0000, 32'h0000_5500, 1, 0, 8'h00, 0, 2'd2, 4'b0000);
        add_vec(4'b0011, 4'b0001, 32'h0000_5566, 0, 1, 8'hF1, 1, 2'd1, 4'b0000);
        add_vec(4'b0011, 4'b0001, 32'h0000_5566, 1, 1, 8'hF1, 1, 2'd1, 4'b0000);
        add_vec(4'b0011, 4'b0001, 32'h0000_5566, 1, 1, 8'h55, 1, 2'd1, 4'b0010);
        add_vec(4'b0001, 4'b0001, 32'h0000_7766, 1, 0, 8'h77, 1, 2'd1, 4'b0010);
        add_vec(4'b0001, 4'b0001, 32'h0000_7766, 1, 0, 8'h77, 1, 2'd1, 4'b0010);
        add_vec(4'b0001, 4'b0001, 32'h0000_7766, 1, 0, 8'h77, 1, 2'd1, 4'b0010);
        add_vec(4'b0011, 4'b0011, 32'h0000_7766, 1, 1, 8'h77, 1, 2'd1, 4'b0010);
        add_vec(4'b0001, 4'b0001, 32'h0000_0066, 1, 0, 8'h00, 0, 2'd1, 4'b0000);
        add_vec(4'b0001, 4'b0001, 32'h0000_0066, 1, 1, 8'hF0, 1, 2'd0, 4'b0000);
        add_vec(4'b0001, 4'b0001, 32'h0000_0066, 1, 1, 8'h66, 1, 2'd0, 4'b0001);
        add_vec(4'b0000, 4'b0000, 32'h0000_0000, 1, 0, 8'h00, 0, 2'd0, 4'b0000);

        do_reset();

        // Directed cycle table: single source, header hold, lock vs intruder.
        foreach (vecs[i]) begin
            s_tvalid = vecs[i].tv;
            s_tlast  = vecs[i].tl;
            s_tdata  = vecs[i].td;
            m_tready = vecs[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d_mvalid", i), 32'(m_tvalid), 32'(vecs[i].ev));
            chk($sformatf("vec%0d_mdata", i), 32'(m_tdata), 32'(vecs[i].ed));
            chk($sformatf("vec%0d_gv", i), 32'(gv), 32'(vecs[i].eg));
            chk($sformatf("vec%0d_gidx", i), 32'(gidx), 32'(vecs[i].ei));
            chk($sformatf("vec%0d_sready", i), 32'(s_tready), 32'(vecs[i].es));
            @(posedge clk);
            #1;
        end
        zero_inputs();

        // Fairness: every port holds two 2-beat packets.
        do_reset();
        for (int p = 0; p < 4; p++) gen_packets(p, 2, 2, 2);
        run_traffic(0, 1'b0, 2000, "rr");

        // Backpressure: tready one cycle in ten.
        do_reset();
        for (int p = 0; p < 4; p++) gen_packets(p, $urandom_range(2, 1), 1, 3);
        run_traffic(2, 1'b0, 6000, "bp");

        // Random traffic with bubbles and random ready.
        for (int it = 0; it < 4; it++) begin
            do_reset();
            for (int p = 0; p < 4; p++) gen_packets(p, $urandom_range(3, 0), 1, 4);
            run_traffic(1, 1'b1, 4000, $sformatf("rnd%0d", it));
        end

        // Header-less instance: single-beat packets on ports 0 and 3.
        do_reset();
        n_tvalid = 4'b1001;
        n_tlast  = 4'b1001;
        n_tdata  = 32'hBB00_00AA;
        n_mready = 1'b1;
        for (int c = 0; c < 20 && nobs.size() < 2; c++) begin
            @(negedge clk);
            if (n_mvalid && n_mready) nobs.push_back(n_mdata);
            hsn = n_tvalid & n_tready_s;
            @(posedge clk);
            #1;
            n_tvalid = n_tvalid & ~hsn;
        end
        chk("nohdr_len", 32'(nobs.size()), 32'd2);
        if (nobs.size() >= 2) begin
            chk("nohdr_beat0", 32'(nobs[0]), 32'hAA);
            chk("nohdr_beat1", 32'(nobs[1]), 32'hBB);
        end
        zero_inputs();

        // Asynchronous reset during the second payload beat.
        do_reset();
        s_tvalid = 4'b0100;
        s_tlast  = 4'b0000;
        s_tdata  = 32'h0031_0000;
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        s_tdata = 32'h0032_0000;
        @(negedge clk);
        chk("midrst_pre_mvalid", 32'(m_tvalid), 32'd1);
        chk("midrst_pre_mdata", 32'(m_tdata), 32'h32);
        chk("midrst_pre_gv", 32'(gv), 32'd1);
        #1;
        arst = 1'b1;
        #1;
        chk("midrst_mvalid", 32'(m_tvalid), 32'd0);
        chk("midrst_gv", 32'(gv), 32'd0);
        chk("midrst_sready", 32'(s_tready), 32'd0);
        do_reset();
        b.data = 8'hA0; b.last = 1'b1; src_q[0].push_back(b);
        b.data = 8'hB0; b.last = 1'b0; src_q[1].push_back(b);
        b.data = 8'hB1; b.last = 1'b1; src_q[1].push_back(b);
        run_traffic(0, 1'b0, 200, "postrst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
